// File: rtl/m1_word_serializer.sv
// m1_word_serializer
//   Walks the 128-word M1 frame buffer one word at a time. For each word it
//   issues a single-cycle request, captures the returned word, and shifts it
//   out MSB-first. Each serial bit is held for BIT_DIV clocks.
//
//   Optional build macro: M1_PARITY_EN
//     When defined, one odd-parity bit follows the WORD_W data bits.
//
//   Ports
//     clk          system clock, rising edge
//     reset        asynchronous, active-low reset
//     enable       run request, sampled in IDLE and at word end
//     dataWord     word from filler, valid the cycle after bufGetWord
//     bufGetWord   single-cycle word request
//     bufRdPointer word index presented with bufGetWord
//     serOut       serial data, MSB first
//     bitStrobe    pulse on the first clock of each serial bit
//     wordStrobe   pulse when a word enters the shifter
//     frameStart   pulse with wordStrobe when the captured word is index 0
//     busy         high whenever the FSM is not IDLE
module m1_word_serializer #(
    parameter int WORD_W  = 12,
    parameter int PTR_W   = 7,
    parameter int BIT_DIV = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [WORD_W-1:0] dataWord,
    output logic              bufGetWord,
    output logic [PTR_W-1:0]  bufRdPointer,
    output logic              serOut,
    output logic              bitStrobe,
    output logic              wordStrobe,
    output logic              frameStart,
    output logic              busy
);

`ifdef M1_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    // Serial bits per word, including the parity bit when it is enabled.
    localparam int NB     = WORD_W + PAR_BITS;
    localparam int DIV_W  = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam int BCNT_W = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [1:0] {IDLE, REQ, LOAD, SHIFT} state_t;

    state_t            state;
    logic [NB-1:0]     shifter;
    logic [DIV_W-1:0]  div;
    logic [BCNT_W-1:0] bitcnt;

    // The parity bit is placed below the data so that it simply shifts out
    // last, with no special case in the shifting logic.
    function automatic logic [NB-1:0] frame_word(input logic [WORD_W-1:0] w);
`ifdef M1_PARITY_EN
        return {w, ~^w};
`else
        return w;
`endif
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            shifter      <= '0;
            div          <= '0;
            bitcnt       <= '0;
            bufGetWord   <= 1'b0;
            bufRdPointer <= '0;
            serOut       <= 1'b0;
            bitStrobe    <= 1'b0;
            wordStrobe   <= 1'b0;
            frameStart   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            // The strobes are single-cycle pulses unless a branch below
            // raises them again.
            bufGetWord <= 1'b0;
            bitStrobe  <= 1'b0;
            wordStrobe <= 1'b0;
            frameStart <= 1'b0;
            case (state)
                IDLE: begin
                    serOut <= 1'b0;
                    if (enable) begin
                        state      <= REQ;
                        bufGetWord <= 1'b1;
                        busy       <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                REQ: begin
                    state <= LOAD;
                end
                LOAD: begin
                    // The filler returns the word during this cycle. The
                    // first bit is therefore driven out from the next cycle.
                    shifter    <= frame_word(dataWord);
                    serOut     <= dataWord[WORD_W-1];
                    wordStrobe <= 1'b1;
                    frameStart <= (bufRdPointer == '0);
                    bitStrobe  <= 1'b1;
                    div        <= '0;
                    bitcnt     <= '0;
                    state      <= SHIFT;
                end
                SHIFT: begin
                    if (div == DIV_W'(BIT_DIV - 1)) begin
                        div <= '0;
                        if (bitcnt == BCNT_W'(NB - 1)) begin
                            // At word end, advance the pointer. It wraps
                            // naturally at 2**PTR_W.
                            bufRdPointer <= bufRdPointer + 1'b1;
                            serOut       <= 1'b0;
                            if (enable) begin
                                state      <= REQ;
                                bufGetWord <= 1'b1;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            bitcnt    <= bitcnt + 1'b1;
                            shifter   <= shifter << 1;
                            serOut    <= shifter[NB-2];
                            bitStrobe <= 1'b1;
                        end
                    end else begin
                        div <= div + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m1_word_serializer.sv
module tb_m1_word_serializer;

    localparam int WORD_W  = 12;
    localparam int PTR_W   = 7;
    localparam int BIT_DIV = 4;
`ifdef M1_PARITY_EN
    localparam int NB = WORD_W + 1;
`else
    localparam int NB = WORD_W;
`endif
    localparam int PERIOD = 2 + NB * BIT_DIV;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              enable = 1'b0;
    logic [WORD_W-1:0] dataWord = '0;
    logic              bufGetWord;
    logic [PTR_W-1:0]  bufRdPointer;
    logic              serOut, bitStrobe, wordStrobe, frameStart, busy;

    m1_word_serializer #(.WORD_W(WORD_W), .PTR_W(PTR_W), .BIT_DIV(BIT_DIV)) dut (
        .clk(clk), .reset(reset), .enable(enable), .dataWord(dataWord),
        .bufGetWord(bufGetWord), .bufRdPointer(bufRdPointer), .serOut(serOut),
        .bitStrobe(bitStrobe), .wordStrobe(wordStrobe), .frameStart(frameStart),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [PTR_W-1:0]  p;
        logic [WORD_W-1:0] w;
    } ent_t;

    ent_t              sb[$];
    logic [WORD_W-1:0] mem [2**PTR_W];
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Monitor and filler model state.
    int               cyc = 0;
    int               req_cnt = 0, load_cnt = 0, done_cnt = 0, frame_cnt = 0;
    int               prev_req = -1;
    bit               period_chk = 0, toggle = 0;
    bit               load_next = 0;
    logic [PTR_W-1:0] last_ptr = '0;
    logic [PTR_W-1:0] exp_ptr = '0;
    logic [PTR_W-1:0] last_req_ptr = '0, last_done_ptr = '0, cur_ptr = '0;
    bit               active = 0;
    int               bi = 0, dc = 0;
    logic [NB-1:0]    expw = '0;
    logic             prev_get = 1'b0;
    ent_t             e;

    always @(negedge clk) begin
        cyc++;
        // Filler: the word is valid only during the cycle after the request.
        // Otherwise dataWord holds its value, or takes random junk in toggle mode.
        if (load_next) dataWord = mem[last_ptr];
        else if (toggle) dataWord = WORD_W'($urandom);
        load_next = bufGetWord;
        last_ptr  = bufRdPointer;

        if (!reset) begin
            active   = 0;
            exp_ptr  = '0;
            prev_req = -1;
            prev_get = 1'b0;
            sb.delete();
        end else begin
            chk("getword_double", {31'd0, bufGetWord & prev_get}, 32'd0);
            prev_get = bufGetWord;
            if (bufGetWord) begin
                chk("req_ptr", {25'd0, bufRdPointer}, {25'd0, exp_ptr});
                chk("busy_req", {31'd0, busy}, 32'd1);
                if (period_chk && prev_req >= 0)
                    chk("word_period", cyc - prev_req, PERIOD);
                prev_req = cyc;
                exp_ptr = exp_ptr + 1'b1;
                last_req_ptr = bufRdPointer;
                req_cnt++;
                sb.push_back({bufRdPointer, mem[bufRdPointer]});
            end
            if (wordStrobe) begin
                load_cnt++;
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                    e = '0;
                end else begin
                    e = sb.pop_front();
                end
                cur_ptr = e.p;
                chk("frameStart", {31'd0, frameStart}, {31'd0, e.p == '0});
                if (frameStart) frame_cnt++;
`ifdef M1_PARITY_EN
                expw = {e.w, ~^e.w};
`else
                expw = e.w;
`endif
                active = 1; bi = 0; dc = 0;
            end else begin
                chk("frameStart_alone", {31'd0, frameStart}, 32'd0);
            end
            if (active) begin
                chk("bitStrobe", {31'd0, bitStrobe}, {31'd0, dc == 0});
                chk("serOut", {31'd0, serOut}, {31'd0, expw[NB-1-bi]});
                dc++;
                if (dc == BIT_DIV) begin
                    dc = 0; bi++;
                    if (bi == NB) begin
                        active = 0;
                        done_cnt++;
                        last_done_ptr = cur_ptr;
                    end
                end
            end else begin
                chk("serOut_gap", {31'd0, serOut}, 32'd0);
                chk("bitStrobe_gap", {31'd0, bitStrobe}, 32'd0);
            end
        end
    end

    int snap;

    initial begin
        for (int i = 0; i < 2**PTR_W; i++) mem[i] = WORD_W'(i * 37 + 'h155);
        mem[2]  = 12'h378;
        mem[3]  = 12'h001;
        mem[11] = 12'hFFF;
        mem[12] = 12'h000;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_getword", {31'd0, bufGetWord}, 32'd0);
        chk("rst_ptr", {25'd0, bufRdPointer}, 32'd0);
        chk("rst_serOut", {31'd0, serOut}, 32'd0);
        chk("rst_strobes", {29'd0, bitStrobe, wordStrobe, frameStart}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        // Free run: a full frame plus the first word of the next frame
        reset = 1'b1;
        enable = 1'b1;
        period_chk = 1;
        for (int i = 0; i < 140 * PERIOD && load_cnt < 129; i++) @(negedge clk);
        chk("freerun_loads", load_cnt, 129);
        chk("freerun_frames", frame_cnt, 2);
        chk("freerun_wrap_ptr", {25'd0, last_req_ptr}, 32'd0);

        // Async reset in the middle of a word at bit 7
        for (int i = 0; i < 2 * PERIOD && !(active && bi == 7); i++) @(negedge clk);
        chk("reach_bit7", {31'd0, active && bi == 7}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("midrst_serOut", {31'd0, serOut}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_strobes", {28'd0, bitStrobe, wordStrobe, frameStart, bufGetWord}, 32'd0);
        chk("midrst_ptr", {25'd0, bufRdPointer}, 32'd0);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        snap = req_cnt;
        for (int i = 0; i < 10 && req_cnt == snap; i++) @(negedge clk);
        chk("post_rst_req_ptr", {25'd0, last_req_ptr}, 32'd0);

        // Drop enable at bit 5 of the pointer-9 word
        period_chk = 0;
        for (int i = 0; i < 12 * PERIOD && !(active && cur_ptr == 9 && bi == 5); i++) @(negedge clk);
        chk("reach_p9_bit5", {31'd0, active && cur_ptr == 9 && bi == 5}, 32'd1);
        enable = 1'b0;
        for (int i = 0; i < 2 * PERIOD && busy; i++) @(negedge clk);
        chk("drop_busy", {31'd0, busy}, 32'd0);
        chk("drop_last_word", {25'd0, last_done_ptr}, 32'd9);
        chk("drop_word_done", {31'd0, active}, 32'd0);
        snap = req_cnt;
        repeat (20) @(negedge clk);
        chk("idle_no_req", req_cnt, snap);
        enable = 1'b1;
        for (int i = 0; i < 10 && req_cnt == snap; i++) @(negedge clk);
        chk("resume_ptr", {25'd0, last_req_ptr}, 32'd10);

        // dataWord driven with junk on every edge except the LOAD edge
        toggle = 1;
        snap = done_cnt;
        for (int i = 0; i < 5 * PERIOD && done_cnt < snap + 3; i++) @(negedge clk);
        chk("toggle_words", done_cnt, snap + 3);
        toggle = 0;

        // Wind down
        enable = 1'b0;
        for (int i = 0; i < 2 * PERIOD && busy; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("final_idle", {31'd0, busy}, 32'd0);
        chk("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
